// File: rtl/add_subb_pipe.sv
// Pipelined signed add/subtract with independent operand negation for the BKM FPU datapath.
// The sum is formed at the head of the pipe; the remaining register levels re-time it.
module add_subb_pipe #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  input  logic         subb_a,
  input  logic         subb_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         clr_ovf,
  output logic         out_valid,
  output logic         c,
  output logic [W-1:0] s,
  output logic         ovf,
  output logic         ovf_sticky
);

  // Stage payload: {ovf, c, s}
  localparam int DW = W + 2;

  logic signed [W+1:0] ae, be, an, bn, r;
  logic                ovf_c;
  logic [DW-1:0]       res_w;

  assign ae = $signed({{2{a[W-1]}}, a});
  assign be = $signed({{2{b[W-1]}}, b});
  assign an = subb_a ? -ae : ae;
  assign bn = subb_b ? -be : be;
  assign r  = an + bn;
  // r fits W signed bits only when its top three bits agree
  assign ovf_c = ~((r[W+1:W-1] == 3'b000) | (r[W+1:W-1] == 3'b111));
  assign res_w = {ovf_c, r[W:0]};

  logic [STAGES-1:0]         vld_q, vld_in;
  logic [STAGES-1:0][DW-1:0] dat_q, dat_in;

  always_comb begin
    vld_in    = '0;
    dat_in    = '0;
    vld_in[0] = in_valid;
    dat_in[0] = res_w;
    for (int i = 1; i < STAGES; i++) begin
      vld_in[i] = vld_q[i-1];
      dat_in[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (ena) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= vld_in[i];
        if (vld_in[i]) dat_q[i] <= dat_in[i];
      end
    end
  end

  logic ovf_sticky_q, ovf_sticky_d;
  logic last_load_ovf;

  assign last_load_ovf = ena & vld_in[STAGES-1] & dat_in[STAGES-1][DW-1];
  assign ovf_sticky_d  = (ovf_sticky_q & ~clr_ovf) | last_load_ovf;

  always_ff @(posedge clk) begin
    if (rst) ovf_sticky_q <= 1'b0;
    else     ovf_sticky_q <= ovf_sticky_d;
  end

  assign out_valid  = vld_q[STAGES-1];
  assign ovf        = dat_q[STAGES-1][DW-1];
  assign c          = dat_q[STAGES-1][W];
  assign s          = dat_q[STAGES-1][W-1:0];
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_add_subb_pipe.sv
// Directed bench for add_subb_pipe (W=4, STAGES=2): hand vectors, exhaustive stall stream, sticky and reset.
module tb_add_subb_pipe;
  localparam int W = 4;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst, ena, in_valid, subb_a, subb_b, clr_ovf;
  logic [W-1:0] a, b;
  logic         out_valid, c, ovf, ovf_sticky;
  logic [W-1:0] s;

  int checks = 0;
  int failures = 0;

  add_subb_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid),
    .subb_a(subb_a), .subb_b(subb_b), .a(a), .b(b), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .c(c), .s(s), .ovf(ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; one tick = rising edge then the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic sa, input logic sb,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = v; subb_a = sa; subb_b = sb; a = av; b = bv;
  endtask

  // Independent reference: {ovf, c, s}
  function automatic logic [5:0] model(input logic sa, input logic sb,
                                       input logic [3:0] av, input logic [3:0] bv);
    int x, y, r;
    logic [31:0] rv;
    x = int'($signed(av));
    y = int'($signed(bv));
    r = (sa ? -x : x) + (sb ? -y : y);
    rv = r;
    return {(r < -8 || r > 7), rv[4], rv[3:0]};
  endfunction

  logic [5:0] exp_q[$];
  logic [5:0] e;
  int idx, cyc, got;
  logic en_now, prev_ov;
  logic [5:0] prev_out;

  initial begin
    rst = 1'b1; ena = 1'b1; clr_ovf = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    tick();
    tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_cso", {26'd0, ovf, c, s}, 32'd0);
    chk("reset_sticky", {31'd0, ovf_sticky}, 32'd0);

    // 1: 3+2 appears two edges later
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd3, 4'd2);
    tick();
    chk("t1_not_yet", {26'd0, out_valid, ovf, c, s}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    chk("t1_result", {26'd0, out_valid, ovf, c, s}, {26'd0, 1'b1, 1'b0, 1'b0, 4'b0101});
    tick();
    chk("t1_pulse_end", {31'd0, out_valid}, 32'd0);
    chk("t1_hold", {27'd0, c, s}, 32'h05);

    // 2: overflow then non-overflow, sticky stays
    drive(1'b1, 1'b0, 1'b0, 4'd7, 4'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'b1101, 4'b1110);
    tick();
    chk("t2_ovf_res", {26'd0, out_valid, ovf, c, s}, {26'd0, 4'b1_1_0_1, 3'b000});
    chk("t2_sticky_set", {31'd0, ovf_sticky}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    chk("t2_r1", {26'd0, out_valid, ovf, c, s}, {26'd0, 1'b1, 1'b0, 1'b0, 4'b0001});
    chk("t2_sticky_held", {31'd0, ovf_sticky}, 32'd1);

    // 3: -(-8) - (-8) = +16 and -(-8) + 0 = +8
    drive(1'b1, 1'b1, 1'b1, 4'b1000, 4'b1000);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000);
    tick();
    chk("t3_plus16", {26'd0, out_valid, ovf, c, s}, {26'd0, 1'b1, 1'b1, 1'b1, 4'b0000});
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    chk("t3_plus8", {26'd0, out_valid, ovf, c, s}, {26'd0, 1'b1, 1'b1, 1'b0, 4'b1000});

    // 5: sticky clear with ena=0, then set-wins-over-clear
    ena = 1'b0; clr_ovf = 1'b1;
    tick();
    chk("t5_clr_stalled", {31'd0, ovf_sticky}, 32'd0);
    chk("t5_stall_hold_valid", {31'd0, out_valid}, 32'd1);
    ena = 1'b1; clr_ovf = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd7, 4'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    clr_ovf = 1'b1;
    tick();
    chk("t5_set_wins", {30'd0, ovf, ovf_sticky}, 32'd3);
    tick();
    chk("t5_clr_alone", {31'd0, ovf_sticky}, 32'd0);
    clr_ovf = 1'b0;

    // 4: all 1024 vectors, ena low every third cycle
    idx = 0; cyc = 0; got = 0;
    while ((idx < 1024 || exp_q.size() != 0) && cyc < 4000) begin
      en_now = (cyc % 3) != 2;
      ena = en_now;
      prev_ov = out_valid;
      prev_out = {ovf, c, s};
      if (idx < 1024) begin
        drive(1'b1, idx[9], idx[8], idx[7:4], idx[3:0]);
        if (en_now) exp_q.push_back(model(idx[9], idx[8], idx[7:4], idx[3:0]));
      end else begin
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      end
      tick();
      if (!en_now) begin
        chk("t4_freeze", {25'd0, out_valid, ovf, c, s}, {25'd0, prev_ov, prev_out});
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("t4_extra_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("t4_result", {26'd0, ovf, c, s}, {26'd0, e});
          got++;
        end
      end
      if (en_now && idx < 1024) idx++;
      cyc++;
    end
    chk("t4_count", got, 32'd1024);
    ena = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    tick();

    // 6: reset with two vectors in flight and one on the reset edge
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd3, 4'd3);
    rst = 1'b1;
    tick();
    chk("t6_rst_edge", {26'd0, out_valid, ovf, c, s}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    chk("t6_post1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t6_post2", {26'd0, out_valid, ovf, c, s}, 32'd0);
    tick();
    chk("t6_post3", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
